// File: rtl/control_decode_pkg.sv
// Shared decode constants: opcodes, ALU class codes and the ALU command set used by decode and the ALU.
// Also provides the R/I arithmetic command lookup reused by the ALU command decoder.
package control_decode_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_R      = 2'b10,
      ALUOP_I      = 2'b11
   } alu_op_e;

   typedef enum logic [3:0] {
      CMD_ADD  = 4'b0000,
      CMD_SUB  = 4'b0001,
      CMD_AND  = 4'b0010,
      CMD_OR   = 4'b0011,
      CMD_XOR  = 4'b0100,
      CMD_SLL  = 4'b0101,
      CMD_SRL  = 4'b0110,
      CMD_SRA  = 4'b0111,
      CMD_SLT  = 4'b1000,
      CMD_SLTU = 4'b1001,
      CMD_BEQ  = 4'b1010,
      CMD_BNE  = 4'b1011,
      CMD_BLT  = 4'b1100,
      CMD_BGE  = 4'b1101,
      CMD_BLTU = 4'b1110,
      CMD_BGEU = 4'b1111
   } alu_cmd_e;

   typedef struct packed {
      logic    branch;
      logic    mem_read;
      logic    mem_to_reg;
      logic    mem_write;
      logic    alu_src;
      logic    reg_write;
      alu_op_e alu_op;
   } ctrl_t;

   // sub_ok separates R-type (funct7[5] selects SUB) from I-type (bit is immediate data)
   function automatic alu_cmd_e arith_cmd(input logic [2:0] f3, input logic alt, input logic sub_ok);
      alu_cmd_e cmd;
      case (f3)
         3'b000:  cmd = (alt && sub_ok) ? CMD_SUB : CMD_ADD;
         3'b001:  cmd = CMD_SLL;
         3'b010:  cmd = CMD_SLT;
         3'b011:  cmd = CMD_SLTU;
         3'b100:  cmd = CMD_XOR;
         3'b101:  cmd = alt ? CMD_SRA : CMD_SRL;
         3'b110:  cmd = CMD_OR;
         default: cmd = CMD_AND;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/alu_cmd_decode.sv
// Combinational ALU command decode from (ALUOp, {funct7[0], funct7[5], funct3}); zero latency.
// No flow control: pure function of its inputs, registered by the parent.
module alu_cmd_decode
   import control_decode_pkg::*;
(
   input  alu_op_e    alu_op,
   input  logic [4:0] alu_funct,
   output alu_cmd_e   alu_cmd,
   output logic       is_mul,
   output logic       illegal
);

   logic [2:0] f3;
   logic       f7_alt;
   logic       f7_mul;

   assign f3     = alu_funct[2:0];
   assign f7_alt = alu_funct[3];
   assign f7_mul = alu_funct[4];

   always_comb begin
      alu_cmd = CMD_ADD;
      is_mul  = 1'b0;
      illegal = 1'b0;
      case (alu_op)
         ALUOP_MEM: alu_cmd = CMD_ADD;
         ALUOP_BRANCH: begin
            case (f3)
               3'b000:  alu_cmd = CMD_BEQ;
               3'b001:  alu_cmd = CMD_BNE;
               3'b100:  alu_cmd = CMD_BLT;
               3'b101:  alu_cmd = CMD_BGE;
               3'b110:  alu_cmd = CMD_BLTU;
               3'b111:  alu_cmd = CMD_BGEU;
               default: illegal = 1'b1;
            endcase
         end
         ALUOP_R: begin
            // M-extension: the ALU receives funct3 directly as its mul/div selector
            if (f7_mul) begin
               is_mul  = 1'b1;
               alu_cmd = alu_cmd_e'({1'b0, f3});
            end else begin
               alu_cmd = arith_cmd(f3, f7_alt, 1'b1);
            end
         end
         default: alu_cmd = arith_cmd(f3, f7_alt, 1'b0);
      endcase
   end

endmodule

// File: rtl/control_decode.sv
// RV32IM decode control: opcode + funct decode registered at the ID/EX boundary; latency 1 cycle.
// en=0 stalls by holding all outputs; rst (sync, active-high) clears them and wins over en.
module control_decode
   import control_decode_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] instr,
   output logic        Branch,
   output logic        MemRead,
   output logic        MemtoReg,
   output logic        MemWrite,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic [1:0]  ALUOp,
   output logic [3:0]  ALU_cmd,
   output logic        IsMul,
   output logic        illegal
);

   ctrl_t      ctl_d;
   logic       op_illegal;
   logic [4:0] alu_funct;
   alu_cmd_e   cmd_d;
   logic       mul_d;
   logic       funct_illegal;
   logic       unused_instr_bits;

   ctrl_t      ctl_q;
   alu_cmd_e   cmd_q;
   logic       mul_q;
   logic       ill_q;

   assign alu_funct         = {instr[25], instr[30], instr[14:12]};
   assign unused_instr_bits = ^{instr[31], instr[29:26], instr[24:15], instr[11:7]};

   always_comb begin
      ctl_d      = '0;
      op_illegal = 1'b0;
      case (instr[6:0])
         OP_R:      ctl_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_R};
         OP_I:      ctl_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALUOP_I};
         OP_LOAD:   ctl_d = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALUOP_MEM};
         OP_STORE:  ctl_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALUOP_MEM};
         OP_BRANCH: ctl_d = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_BRANCH};
         default:   op_illegal = 1'b1;
      endcase
   end

   alu_cmd_decode u_alu_cmd_decode (
      .alu_op    (ctl_d.alu_op),
      .alu_funct (alu_funct),
      .alu_cmd   (cmd_d),
      .is_mul    (mul_d),
      .illegal   (funct_illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ctl_q <= '0;
         cmd_q <= CMD_ADD;
         mul_q <= 1'b0;
         ill_q <= 1'b0;
      end else if (en) begin
         ctl_q <= ctl_d;
         cmd_q <= cmd_d;
         mul_q <= mul_d;
         ill_q <= op_illegal | funct_illegal;
      end
   end

   assign Branch   = ctl_q.branch;
   assign MemRead  = ctl_q.mem_read;
   assign MemtoReg = ctl_q.mem_to_reg;
   assign MemWrite = ctl_q.mem_write;
   assign ALUSrc   = ctl_q.alu_src;
   assign RegWrite = ctl_q.reg_write;
   assign ALUOp    = ctl_q.alu_op;
   assign ALU_cmd  = cmd_q;
   assign IsMul    = mul_q;
   assign illegal  = ill_q;

endmodule

// File: tb/tb_control_decode.sv
// Self-checking bench for control_decode: expected output words are queued at drive time and
// popped for comparison one edge later.
module tb_control_decode;

   // {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp[1:0], ALU_cmd[3:0], IsMul, illegal}
   typedef logic [13:0] exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] instr;
   logic        Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, IsMul, illegal;
   logic [1:0]  ALUOp;
   logic [3:0]  ALU_cmd;

   exp_t exp_q[$];
   exp_t last_exp;
   exp_t obs;
   exp_t want;
   int   vectors     = 0;
   int   miscompares = 0;

   control_decode dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .instr    (instr),
      .Branch   (Branch),
      .MemRead  (MemRead),
      .MemtoReg (MemtoReg),
      .MemWrite (MemWrite),
      .ALUSrc   (ALUSrc),
      .RegWrite (RegWrite),
      .ALUOp    (ALUOp),
      .ALU_cmd  (ALU_cmd),
      .IsMul    (IsMul),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   assign obs = {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, ALU_cmd, IsMul, illegal};

   // Reference decoder, written as a flat lookup per opcode
   function automatic exp_t model(input logic [31:0] i);
      logic [7:0] ctl;
      logic [3:0] cmd;
      logic       mul;
      logic       ill;
      logic [2:0] f3;
      f3  = i[14:12];
      ctl = 8'b0;
      cmd = 4'b0000;
      mul = 1'b0;
      ill = 1'b0;
      case (i[6:0])
         7'b0110011: begin
            ctl = 8'b000001_10;
            if (i[25]) begin
               mul = 1'b1;
               cmd = {1'b0, f3};
            end else begin
               case (f3)
                  3'd0: cmd = i[30] ? 4'b0001 : 4'b0000;
                  3'd1: cmd = 4'b0101;
                  3'd2: cmd = 4'b1000;
                  3'd3: cmd = 4'b1001;
                  3'd4: cmd = 4'b0100;
                  3'd5: cmd = i[30] ? 4'b0111 : 4'b0110;
                  3'd6: cmd = 4'b0011;
                  3'd7: cmd = 4'b0010;
               endcase
            end
         end
         7'b0010011: begin
            ctl = 8'b000011_11;
            case (f3)
               3'd0: cmd = 4'b0000;
               3'd1: cmd = 4'b0101;
               3'd2: cmd = 4'b1000;
               3'd3: cmd = 4'b1001;
               3'd4: cmd = 4'b0100;
               3'd5: cmd = i[30] ? 4'b0111 : 4'b0110;
               3'd6: cmd = 4'b0011;
               3'd7: cmd = 4'b0010;
            endcase
         end
         7'b0000011: ctl = 8'b011011_00;
         7'b0100011: ctl = 8'b000110_00;
         7'b1100011: begin
            ctl = 8'b100000_01;
            case (f3)
               3'd0: cmd = 4'b1010;
               3'd1: cmd = 4'b1011;
               3'd4: cmd = 4'b1100;
               3'd5: cmd = 4'b1101;
               3'd6: cmd = 4'b1110;
               3'd7: cmd = 4'b1111;
               default: ill = 1'b1;
            endcase
         end
         default: ill = 1'b1;
      endcase
      return {ctl, cmd, mul, ill};
   endfunction

   // Drive at the falling edge, let one rising edge pass, return at the next falling edge
   task automatic cycle(input logic [31:0] i, input logic e, input logic r);
      instr = i;
      en    = e;
      rst   = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      cycle(32'h0000_0033, 1'b1, 1'b1);
      exp_q.push_back(14'b0);
      cycle(32'h0000_0033, 1'b1, 1'b1);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
         miscompares++;
         $display("FAIL reset: got %b want %b", obs, want);
      end
      last_exp = 14'b0;
   endtask

   task automatic test_rtype();
      logic [31:0] iv[3];
      exp_t        ev[3];
      iv = '{{7'b0000000, 5'b01001, 5'b10101, 3'b000, 5'b01001, 7'b0110011},
             {7'b0000001, 5'd2, 5'd3, 3'b100, 5'd4, 7'b0110011},
             {7'b0100000, 5'd2, 5'd3, 3'b000, 5'd4, 7'b0110011}};
      ev = '{14'b000001_10_0000_0_0, 14'b000001_10_0100_1_0, 14'b000001_10_0001_0_0};
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(ev[k]);
         cycle(iv[k], 1'b1, 1'b0);
         want = exp_q.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL rtype[%0d]: got %b want %b", k, obs, want);
         end
         last_exp = want;
      end
   endtask

   task automatic test_itype();
      logic [31:0] iv[3];
      exp_t        ev[3];
      iv = '{{12'b000000001001, 5'd1, 3'b001, 5'd2, 7'b0010011},
             {12'h400, 5'd1, 3'b000, 5'd2, 7'b0010011},
             {12'b010000000011, 5'd1, 3'b101, 5'd2, 7'b0010011}};
      ev = '{14'b000011_11_0101_0_0, 14'b000011_11_0000_0_0, 14'b000011_11_0111_0_0};
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(ev[k]);
         cycle(iv[k], 1'b1, 1'b0);
         want = exp_q.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL itype[%0d]: got %b want %b", k, obs, want);
         end
         last_exp = want;
      end
   endtask

   task automatic test_mem();
      logic [31:0] iv[2];
      exp_t        ev[2];
      iv = '{{12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011},
             {7'd0, 5'd3, 5'd1, 3'b010, 5'd4, 7'b0100011}};
      ev = '{14'b011011_00_0000_0_0, 14'b000110_00_0000_0_0};
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(ev[k]);
         cycle(iv[k], 1'b1, 1'b0);
         want = exp_q.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL mem[%0d]: got %b want %b", k, obs, want);
         end
         last_exp = want;
      end
   endtask

   task automatic test_branch_illegal();
      logic [31:0] iv[3];
      exp_t        ev[3];
      iv = '{{7'd0, 5'd2, 5'd1, 3'b100, 5'd8, 7'b1100011},
             {7'd0, 5'd2, 5'd1, 3'b011, 5'd8, 7'b1100011},
             {20'hABCDE, 5'd5, 7'b0110111}};
      ev = '{14'b100000_01_1100_0_0, 14'b100000_01_0000_0_1, 14'b000000_00_0000_0_1};
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(ev[k]);
         cycle(iv[k], 1'b1, 1'b0);
         want = exp_q.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL branch_illegal[%0d]: got %b want %b", k, obs, want);
         end
         last_exp = want;
      end
   endtask

   task automatic test_stall();
      logic [31:0] i;
      exp_q.push_back(14'b000001_10_0001_0_0);
      cycle({7'b0100000, 5'd2, 5'd3, 3'b000, 5'd4, 7'b0110011}, 1'b1, 1'b0);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
         miscompares++;
         $display("FAIL stall_load: got %b want %b", obs, want);
      end
      last_exp = want;
      for (int k = 0; k < 4; k++) begin
         i = $urandom;
         exp_q.push_back(last_exp);
         cycle(i, 1'b0, 1'b0);
         want = exp_q.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got %b want %b", k, obs, want);
         end
      end
   endtask

   task automatic test_reset_mid();
      // reset with en=1 and a valid load: reset wins
      exp_q.push_back(14'b0);
      cycle({12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011}, 1'b1, 1'b1);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
         miscompares++;
         $display("FAIL reset_mid: got %b want %b", obs, want);
      end
      // reload, then reset during a stall
      exp_q.push_back(14'b100000_01_1111_0_0);
      cycle({7'd0, 5'd2, 5'd1, 3'b111, 5'd8, 7'b1100011}, 1'b1, 1'b0);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
         miscompares++;
         $display("FAIL reset_reload: got %b want %b", obs, want);
      end
      exp_q.push_back(14'b0);
      cycle({12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011}, 1'b0, 1'b1);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
         miscompares++;
         $display("FAIL reset_stall: got %b want %b", obs, want);
      end
      exp_q.push_back(14'b0);
      cycle({12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011}, 1'b0, 1'b0);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
         miscompares++;
         $display("FAIL reset_release_held: got %b want %b", obs, want);
      end
      exp_q.push_back(14'b011011_00_0000_0_0);
      cycle({12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011}, 1'b1, 1'b0);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
         miscompares++;
         $display("FAIL reset_first_decode: got %b want %b", obs, want);
      end
      last_exp = want;
   endtask

   task automatic test_back_to_back();
      logic [6:0]  ops[6];
      logic [31:0] i;
      logic        e;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
      for (int k = 0; k < 300; k++) begin
         i = {$urandom} & 32'hFFFF_FF80;
         i[6:0] = ops[$urandom_range(0, 5)];
         e = ($urandom_range(0, 4) != 0);
         if (e) last_exp = model(i);
         exp_q.push_back(last_exp);
         cycle(i, e, 1'b0);
         want = exp_q.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL b2b[%0d] instr=%h en=%b: got %b want %b", k, i, e, obs, want);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      instr    = 32'h0;
      last_exp = 14'b0;
      test_reset();
      test_rtype();
      test_itype();
      test_mem();
      test_branch_illegal();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
